// File: rtl/count_step_decoder.sv
// Receive-side decoder for the 2-bit E/F mod-4 counter.
// Recovers E/F steps, tracks signed position, flags illegal jumps.
module count_step_decoder #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          cnt_in,
    input  logic                in_valid,
    input  logic                err_clr,
    input  logic                pos_clr,
    output logic                e_out,
    output logic                f_out,
    output logic signed [W-1:0] pos,
    output logic                locked,
    output logic                err
);

    typedef enum logic [1:0] {
        UNLOCKED,
        TRACK,
        ERROR
    } state_t;

    state_t     state;
    logic [1:0] prev;
    logic [1:0] d;
    logic       st_hold;
    logic       st_up;
    logic       st_dn;
    logic       st_bad;

    assign d       = cnt_in - prev;
    assign st_hold = (d == 2'd0);
    assign st_up   = (d == 2'd1);
    assign st_bad  = (d == 2'd2);
    assign st_dn   = (d == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= UNLOCKED;
            prev   <= 2'b00;
            e_out  <= 1'b0;
            f_out  <= 1'b0;
            pos    <= '0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            e_out <= 1'b0;
            f_out <= 1'b0;
            unique case (state)
                UNLOCKED: begin
                    if (in_valid) begin
                        prev   <= cnt_in;
                        locked <= 1'b1;
                        state  <= TRACK;
                    end
                end
                TRACK: begin
                    if (in_valid) begin
                        unique case (1'b1)
                            st_hold: prev <= cnt_in;
                            st_up: begin
                                prev  <= cnt_in;
                                e_out <= 1'b1;
                                pos   <= pos + W'(1);
                            end
                            st_dn: begin
                                prev  <= cnt_in;
                                e_out <= 1'b1;
                                f_out <= 1'b1;
                                pos   <= pos - W'(1);
                            end
                            st_bad: begin
                                err    <= 1'b1;
                                locked <= 1'b0;
                                state  <= ERROR;
                            end
                            default: ;
                        endcase
                    end
                end
                ERROR: begin
                    if (err_clr) begin
                        err   <= 1'b0;
                        state <= UNLOCKED;
                    end
                end
                default: state <= UNLOCKED;
            endcase
            // Clear overrides any step taken this cycle.
            if (pos_clr) pos <= '0;
        end
    end

endmodule
